// File: rtl/shift_in_cntr_if.sv
// Sample/word handshake bundle for the counted shift-in deserializer.
// The slave side is the deserializer; the master side feeds samples and consumes words.
interface shift_in_cntr_if #(
    parameter int SIZE    = 8,
    parameter int IN_SIZE = 1
);
    logic               clr;
    logic               se;
    logic [IN_SIZE-1:0] din;
    logic [SIZE-1:0]    dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               lst_cycle;
    logic               busy;
    logic               overrun;

    modport master (
        output clr, se, din, dout_ready,
        input  dout, dout_valid, lst_cycle, busy, overrun
    );

    modport slave (
        input  clr, se, din, dout_ready,
        output dout, dout_valid, lst_cycle, busy, overrun
    );
endinterface

// File: rtl/shift_in_cntr.sv
// Counted serial-to-parallel deserializer with a one-entry valid/ready output buffer.
// Define SHIFT_IN_CNTR_LSB_FIRST_EN to assemble words LSB-first instead of MSB-first.
module shift_in_cntr #(
    parameter int SIZE    = 8,
    parameter int IN_SIZE = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_in_cntr_if.slave bus
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] CNT_WORD = CW'(SIZE);
    localparam logic [CW-1:0] CNT_LANE = CW'(IN_SIZE);

    typedef enum logic {
        S_SHIFT,
        S_FULL
    } state_t;

    state_t          state, state_nxt;
    logic [SIZE-1:0] shreg, shreg_nxt;
    logic [SIZE-1:0] shifted;
    logic [SIZE-1:0] dout_q, dout_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            dout_valid_q, dout_valid_nxt;
    logic            overrun_q, overrun_nxt;
    logic            full;
    logic            buf_free;

    assign full     = (state == S_FULL);
    assign buf_free = !dout_valid_q || bus.dout_ready;

`ifdef SHIFT_IN_CNTR_LSB_FIRST_EN
    assign shifted = {bus.din, shreg[SIZE-1:IN_SIZE]};
`else
    assign shifted = {shreg[SIZE-IN_SIZE-1:0], bus.din};
`endif

    // A consume retires dout unless a new word lands on the same edge, which then overrides it.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        cnt_nxt        = cnt;
        dout_nxt       = dout_q;
        dout_valid_nxt = dout_valid_q;
        overrun_nxt    = overrun_q;

        if (dout_valid_q && bus.dout_ready) begin
            dout_valid_nxt = 1'b0;
        end

        if (full) begin
            if (bus.se) begin
                overrun_nxt = 1'b1;
            end
            if (buf_free) begin
                dout_nxt       = shreg;
                dout_valid_nxt = 1'b1;
                cnt_nxt        = CNT_WORD;
                state_nxt      = S_SHIFT;
            end
        end else if (bus.se) begin
            shreg_nxt = shifted;
            cnt_nxt   = cnt - CNT_LANE;
            if (cnt == CNT_LANE) begin
                if (buf_free) begin
                    dout_nxt       = shifted;
                    dout_valid_nxt = 1'b1;
                    cnt_nxt        = CNT_WORD;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = S_FULL;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SHIFT;
            shreg        <= '0;
            cnt          <= CNT_WORD;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (bus.clr) begin
            state        <= S_SHIFT;
            shreg        <= '0;
            cnt          <= CNT_WORD;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            cnt          <= cnt_nxt;
            dout_q       <= dout_nxt;
            dout_valid_q <= dout_valid_nxt;
            overrun_q    <= overrun_nxt;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.lst_cycle  = (cnt == CNT_LANE) && !full;
    assign bus.busy       = (cnt != CNT_WORD) || full;
endmodule

// File: tb/tb_shift_in_cntr.sv
// Directed bench for shift_in_cntr: a single-lane and a quad-lane instance share clock and reset.
module tb_shift_in_cntr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    shift_in_cntr_if #(.SIZE(8), .IN_SIZE(1)) s ();
    shift_in_cntr_if #(.SIZE(8), .IN_SIZE(4)) q ();

    shift_in_cntr #(.SIZE(8), .IN_SIZE(1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s.slave)
    );

    shift_in_cntr #(.SIZE(8), .IN_SIZE(4)) dut_q (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (q.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHIFT_IN_CNTR_LSB_FIRST_EN
    localparam logic [7:0] EXP_QUAD  = 8'hC3;
    localparam logic [7:0] EXP_ORDER = 8'h53;
`else
    localparam logic [7:0] EXP_QUAD  = 8'h3C;
    localparam logic [7:0] EXP_ORDER = 8'hCA;
`endif

    // Word a serial stream of b[7] first ends up as, given the build's bit order.
    function automatic logic [7:0] exp_word(input logic [7:0] b);
        logic [7:0] r;
`ifdef SHIFT_IN_CNTR_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            s.se  = 1'b1;
            s.din = b[i];
            step();
        end
        s.se = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (s.dout !== 8'h00 || s.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out got dout=%h valid=%b expected 00/0", s.dout, s.dout_valid);
        end
        checks++;
        if (s.busy !== 1'b0 || s.lst_cycle !== 1'b0 || s.overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got busy=%b lst=%b ovr=%b expected 0/0/0", s.busy, s.lst_cycle, s.overrun);
        end
        checks++;
        if (q.busy !== 1'b0 || q.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_quad got busy=%b valid=%b expected 0/0", q.busy, q.dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_serial();
        logic [7:0] bits;
        bits = 8'hA5;
        s.dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            checks++;
            if (s.lst_cycle !== (i == 0)) begin
                errors++;
                $display("[TB] FAIL serial_lst bit %0d got %b expected %b", i, s.lst_cycle, (i == 0));
            end
            s.se  = 1'b1;
            s.din = bits[i];
            step();
        end
        s.se = 1'b0;
        checks++;
        if (s.dout !== exp_word(8'hA5) || s.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL serial_word got %h/%b expected %h/1", s.dout, s.dout_valid, exp_word(8'hA5));
        end
        checks++;
        if (s.busy !== 1'b0 || s.lst_cycle !== 1'b0) begin
            errors++;
            $display("[TB] FAIL serial_idle got busy=%b lst=%b expected 0/0", s.busy, s.lst_cycle);
        end
        step();
        checks++;
        if (s.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL serial_consume got valid=%b expected 0", s.dout_valid);
        end
    endtask

    task automatic test_quad();
        q.dout_ready = 1'b1;
        q.se  = 1'b1;
        q.din = 4'h3;
        step();
        checks++;
        if (q.lst_cycle !== 1'b1 || q.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL quad_half got lst=%b busy=%b expected 1/1", q.lst_cycle, q.busy);
        end
        q.din = 4'hC;
        step();
        q.se = 1'b0;
        checks++;
        if (q.dout !== EXP_QUAD || q.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL quad_word got %h/%b expected %h/1", q.dout, q.dout_valid, EXP_QUAD);
        end
        checks++;
        if (q.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL quad_busy got %b expected 0", q.busy);
        end
    endtask

    task automatic test_backpressure();
        s.dout_ready = 1'b0;
        send_byte(8'h11);
        checks++;
        if (s.dout !== exp_word(8'h11) || s.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_first got %h/%b expected %h/1", s.dout, s.dout_valid, exp_word(8'h11));
        end
        send_byte(8'h22);
        checks++;
        if (s.dout !== exp_word(8'h11) || s.busy !== 1'b1 || s.lst_cycle !== 1'b0 || s.overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_park got dout=%h busy=%b lst=%b ovr=%b expected %h/1/0/0",
                     s.dout, s.busy, s.lst_cycle, s.overrun, exp_word(8'h11));
        end
        s.se  = 1'b1;
        s.din = 1'b1;
        step();
        s.se = 1'b0;
        checks++;
        if (s.overrun !== 1'b1 || s.dout !== exp_word(8'h11)) begin
            errors++;
            $display("[TB] FAIL bp_overrun got ovr=%b dout=%h expected 1/%h", s.overrun, s.dout, exp_word(8'h11));
        end
        s.dout_ready = 1'b1;
        step();
        checks++;
        if (s.dout !== exp_word(8'h22) || s.dout_valid !== 1'b1 || s.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain got %h/%b busy=%b expected %h/1/0", s.dout, s.dout_valid, s.busy, exp_word(8'h22));
        end
        send_byte(8'h5A);
        checks++;
        if (s.dout !== exp_word(8'h5A) || s.dout_valid !== 1'b1 || s.overrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_third got %h/%b ovr=%b expected %h/1/1", s.dout, s.dout_valid, s.overrun, exp_word(8'h5A));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words[0] = 8'hDE;
        words[1] = 8'hAD;
        words[2] = 8'hBE;
        s.clr = 1'b1;
        step();
        s.clr = 1'b0;
        checks++;
        if (s.overrun !== 1'b0 || s.dout_valid !== 1'b0 || s.dout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL b2b_clr got ovr=%b valid=%b dout=%h expected 0/0/00", s.overrun, s.dout_valid, s.dout);
        end
        s.dout_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 7; i >= 0; i--) begin
                s.se  = 1'b1;
                s.din = words[w][i];
                step();
                checks++;
                if (s.dout_valid !== (i == 0)) begin
                    errors++;
                    $display("[TB] FAIL b2b_valid word %0d bit %0d got %b expected %b", w, i, s.dout_valid, (i == 0));
                end
            end
            checks++;
            if (s.dout !== exp_word(words[w])) begin
                errors++;
                $display("[TB] FAIL b2b_word %0d got %h expected %h", w, s.dout, exp_word(words[w]));
            end
        end
        s.se = 1'b0;
        checks++;
        if (s.overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_overrun got %b expected 0", s.overrun);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            s.se  = 1'b1;
            s.din = 1'b1;
            step();
        end
        s.se  = 1'b0;
        s.clr = 1'b1;
        step();
        s.clr = 1'b0;
        checks++;
        if (s.busy !== 1'b0 || s.dout !== 8'h00 || s.dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_state got busy=%b dout=%h valid=%b expected 0/00/0", s.busy, s.dout, s.dout_valid);
        end
        send_byte(8'hF0);
        checks++;
        if (s.dout !== exp_word(8'hF0) || s.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_word got %h/%b expected %h/1", s.dout, s.dout_valid, exp_word(8'hF0));
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            s.se  = 1'b1;
            s.din = 1'b1;
            step();
        end
        s.se = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s.dout !== 8'h00 || s.dout_valid !== 1'b0 || s.busy !== 1'b0 || s.overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arst_now got dout=%h valid=%b busy=%b ovr=%b expected 00/0/0/0",
                     s.dout, s.dout_valid, s.busy, s.overrun);
        end
        #2;
        rst_n = 1'b1;
        send_byte(8'hF0);
        checks++;
        if (s.dout !== exp_word(8'hF0) || s.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arst_word got %h/%b expected %h/1", s.dout, s.dout_valid, exp_word(8'hF0));
        end
    endtask

    task automatic test_lane_order();
        logic [7:0] seq;
        seq = 8'b1100_1010;
        for (int i = 7; i >= 0; i--) begin
            s.se  = 1'b1;
            s.din = seq[i];
            step();
        end
        s.se = 1'b0;
        checks++;
        if (s.dout !== EXP_ORDER || s.dout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lane_order got %h/%b expected %h/1", s.dout, s.dout_valid, EXP_ORDER);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        s.clr        = 1'b0;
        s.se         = 1'b0;
        s.din        = '0;
        s.dout_ready = 1'b0;
        q.clr        = 1'b0;
        q.se         = 1'b0;
        q.din        = '0;
        q.dout_ready = 1'b0;

        test_reset();
        test_serial();
        test_quad();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_lane_order();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
